// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked EXE-stage ALU with internal {Z,C,N,V} status; define ALU_SEQ_MUL_EN to build the iterative multiplier
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] exec_cmd,
  input  logic [WIDTH-1:0] val_1,
  input  logic [WIDTH-1:0] val_2,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       status_reg,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  localparam logic [CMD_W-1:0] OP_MOV = CMD_W'(4'b0001);
  localparam logic [CMD_W-1:0] OP_MVN = CMD_W'(4'b1001);
  localparam logic [CMD_W-1:0] OP_ADD = CMD_W'(4'b0010);
  localparam logic [CMD_W-1:0] OP_ADC = CMD_W'(4'b0011);
  localparam logic [CMD_W-1:0] OP_SUB = CMD_W'(4'b0100);
  localparam logic [CMD_W-1:0] OP_SBC = CMD_W'(4'b0101);
  localparam logic [CMD_W-1:0] OP_AND = CMD_W'(4'b0110);
  localparam logic [CMD_W-1:0] OP_ORR = CMD_W'(4'b0111);
  localparam logic [CMD_W-1:0] OP_EOR = CMD_W'(4'b1000);
  localparam logic [CMD_W-1:0] OP_CMP = CMD_W'(4'b1100);
  localparam logic [CMD_W-1:0] OP_TST = CMD_W'(4'b1110);

`ifdef ALU_SEQ_MUL_EN
  localparam logic [CMD_W-1:0] OP_MUL = CMD_W'(4'b1010);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  state_t state;

  logic             accept;
  logic             is_sub;
  logic             carry_in;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             keep_res;
  logic             force_flags;

  // Logical results only touch N and Z; C and V carry over from the current flags.
  function automatic logic [3:0] nz_flags(input logic [WIDTH-1:0] r, input logic [3:0] f);
    return {(r == '0), f[2], r[MSB], f[0]};
  endfunction

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Shared adder: subtracts are A + ~B + cin, carry-in for ADC/SBC taken from the live C flag.
  always_comb begin
    is_sub = (exec_cmd == OP_SUB) || (exec_cmd == OP_SBC) || (exec_cmd == OP_CMP);
    b_op   = is_sub ? ~val_2 : val_2;
    case (exec_cmd)
      OP_ADC, OP_SBC: carry_in = status_reg[2];
      OP_SUB, OP_CMP: carry_in = 1'b1;
      default:        carry_in = 1'b0;
    endcase
    sum = {1'b0, val_1} + {1'b0, b_op} + {{WIDTH{1'b0}}, carry_in};
    ovf = (sum[MSB] != val_1[MSB]) &&
          (is_sub ? (val_1[MSB] != val_2[MSB]) : (val_1[MSB] == val_2[MSB]));
  end

  // Single-cycle result and flag selection; CMP/TST keep res and always write flags.
  always_comb begin
    alu_res     = '0;
    alu_flags   = status_reg;
    keep_res    = 1'b0;
    force_flags = 1'b0;
    case (exec_cmd)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        alu_res   = sum[MSB:0];
        alu_flags = {(sum[MSB:0] == '0), sum[WIDTH], sum[MSB], ovf};
      end
      OP_CMP: begin
        keep_res    = 1'b1;
        force_flags = 1'b1;
        alu_flags   = {(sum[MSB:0] == '0), sum[WIDTH], sum[MSB], ovf};
      end
      OP_MOV: begin
        alu_res   = val_2;
        alu_flags = nz_flags(val_2, status_reg);
      end
      OP_MVN: begin
        alu_res   = ~val_2;
        alu_flags = nz_flags(~val_2, status_reg);
      end
      OP_AND: begin
        alu_res   = val_1 & val_2;
        alu_flags = nz_flags(val_1 & val_2, status_reg);
      end
      OP_ORR: begin
        alu_res   = val_1 | val_2;
        alu_flags = nz_flags(val_1 | val_2, status_reg);
      end
      OP_EOR: begin
        alu_res   = val_1 ^ val_2;
        alu_flags = nz_flags(val_1 ^ val_2, status_reg);
      end
      OP_TST: begin
        keep_res    = 1'b1;
        force_flags = 1'b1;
        alu_flags   = nz_flags(val_1 & val_2, status_reg);
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0] mul_mplier;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_sum;
  logic [CNT_W-1:0] mul_cnt;
  logic             mul_s;

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    mul_sum = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  end
`else
  assign busy = 1'b0;
`endif

  // Control FSM plus registered result, flags and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      res        <= '0;
      status_reg <= 4'b0000;
      out_valid  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      busy       <= 1'b0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_acc    <= '0;
      mul_cnt    <= '0;
      mul_s      <= 1'b0;
`endif
    end else if (accept) begin
`ifdef ALU_SEQ_MUL_EN
      if (exec_cmd == OP_MUL) begin
        state      <= MUL_BUSY;
        busy       <= 1'b1;
        out_valid  <= 1'b0;
        mul_mcand  <= val_1;
        mul_mplier <= val_2;
        mul_acc    <= '0;
        mul_cnt    <= '0;
        mul_s      <= set_flags;
      end else
`endif
      begin
        state     <= DONE;
        out_valid <= 1'b1;
        if (!keep_res) begin
          res <= alu_res;
        end
        if (set_flags || force_flags) begin
          status_reg <= alu_flags;
        end
      end
    end else begin
      case (state)
`ifdef ALU_SEQ_MUL_EN
        MUL_BUSY: begin
          mul_acc    <= mul_sum;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + CNT_W'(1);
          if (mul_cnt == MUL_LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            res       <= mul_sum;
            if (mul_s) begin
              status_reg <= nz_flags(mul_sum, status_reg);
            end
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor of the single-cycle execute-stage ALU.
- Sits in the EXE stage: accepts one operation per handshake and returns a registered result plus a 4-bit status word {Z,C,N,V}.
- Owns the architectural status register internally, so ADC/SBC carry-in comes from its own flags.
- Adds SBC, CMP/TST flag-only ops, S-bit flag gating and an optional iterative multiplier.

Parameters:
- WIDTH, 32, operand/result width (min 4).
- CMD_W, 4, exec command width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation present.
- in_ready  out  1  block can accept.
- exec_cmd  in  CMD_W  operation code.
- val_1  in  WIDTH  operand A.
- val_2  in  WIDTH  operand B.
- set_flags  in  1  S bit: update status on completion.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- res  out  WIDTH  registered result.
- status_reg  out  4  {Z,C,N,V}, current architectural flags.
- busy  out  1  multiply in progress.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, res=0, status_reg=4'b0000, out_valid=0, busy=0, in_ready=1.
- Accept condition: in_valid & in_ready sampled at clk.
- in_ready = (state==IDLE) | (state==DONE & out_ready), which allows back-to-back single-cycle ops with no bubble.
- Codes:
  - MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101.
  - AND=0110, ORR=0111, EOR=1000.
  - CMP=1100, TST=1110, MUL=1010.
  - All others are undefined.
- Arithmetic: computed at WIDTH+1 bits.
  - ADD: A+B.
  - ADC: A+B+C.
  - SUB/CMP: A+~B+1.
  - SBC: A+~B+C.
  - C = bit WIDTH of the sum. For subtract this means C=1 when there is no borrow (ARM convention).
  - V for add: A[msb]==B[msb] and R[msb]!=A[msb].
  - V for subtract: A[msb]!=B[msb] and R[msb]!=A[msb].
- Logical/MOV/MVN/TST: N and Z from the result; C and V unchanged.
- CMP/TST: res is unchanged (holds its previous value) and out_valid still pulses. Flags are always updated, regardless of set_flags.
- Undefined codes: res=0, flags unchanged, single-cycle.
- FSM states: IDLE, MUL_BUSY, DONE.
  - IDLE, accept of a single-cycle op -> DONE next edge. res and flags are registered on that edge; latency 1.
  - IDLE, accept of MUL -> MUL_BUSY; busy=1.
  - MUL_BUSY: shift-add, one multiplier bit per cycle, WIDTH cycles. Then -> DONE with res = low WIDTH bits of A*B.
  - MUL flags: N and Z only; C and V unchanged.
  - DONE: out_valid=1; res and status are stable until out_ready.
    - out_ready & in_valid -> the new op is accepted the same cycle (next state per the new op).
    - out_ready & !in_valid -> IDLE.
- Flag update: happens on the edge that enters DONE, only if set_flags or the op is CMP/TST. The set_flags value used is the one captured at accept.
- Carry-in for ADC/SBC: uses status C as it stands at the accept edge. This includes a flag written by the immediately preceding op in the same back-to-back cycle: the new value is forwarded.
- Operands: captured at accept; later changes to val_1, val_2 or exec_cmd while busy are ignored.
- rst mid-MUL: aborts the multiply, clears flags and result, returns to IDLE.
- Simultaneous rst and in_valid: rst wins; nothing is accepted.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- When defined: MUL=1010 is executed iteratively as above and busy is driven.
- When undefined:
  - 1010 is treated as an undefined code (res=0, 1-cycle).
  - The MUL_BUSY state and multiplier datapath are not built.
  - busy is tied to 0.

Test Plan:
- Reset, then ADD 32'h7FFFFFFF+1 with set_flags=1 -> one cycle later out_valid=1, res=32'h80000000, status {Z,C,N,V}=0011.
- SUB 5-5, S=1, followed back-to-back by SBC 10-3 with out_ready held 1 -> first res=0, flags 1100. Second res=7 (C=1, no extra borrow), flags 0100, with no idle cycle between the two out_valid pulses.
- CMP 3 vs 7, then TST 8'hF0 & 8'h0F -> res unchanged both times. After CMP: N=1, C=0. After TST: Z=1.
- ADD 1+1 with set_flags=0 after flags 1111 -> res=2, flags remain 1111.
- MUL (macro on, WIDTH=32) 1234*5678 -> busy for 32 cycles, then res=7006652, out_valid held across 3 cycles of out_ready=0, dropping after the handshake.
- rst asserted at MUL cycle 10 -> next cycle busy=0, out_valid=0, status=0000. A following MOV 32'hA5 completes in 1 cycle.
